// File: rtl/trap_csr_unit.sv
// trap_csr_unit
//   Machine-mode CSR file and trap sequencer placed after the EX-stage
//   exception detector. It takes exceptions and mret, updates
//   mstatus/mepc/mcause/mtvec/mscratch, and issues a held PC redirect
//   plus a pipeline flush to fetch. It also executes CSRRW/CSRRS/CSRRC.
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   exp_occur, mret_occur            trap / return event in EX
//   mepc_change, mcause_change       faulting PC and cause code
//   m_status_change                  mstatus OR-mask applied on mret
//   csr_en, csr_op, csr_addr,
//   csr_wdata, csr_src_zero          CSR instruction in EX
//   redirect_ready                   fetch accepts the redirect
//   csr_rdata, csr_addr_bad          old CSR value / unimplemented address (comb)
//   m_status                         current mstatus
//   redirect_valid, redirect_pc,
//   flush                            held redirect to fetch
module trap_csr_unit #(
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exp_occur,
  input  logic        mret_occur,
  input  logic [31:0] mepc_change,
  input  logic [31:0] mcause_change,
  input  logic [31:0] m_status_change,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_src_zero,
  input  logic        redirect_ready,
  output logic [31:0] csr_rdata,
  output logic        csr_addr_bad,
  output logic [31:0] m_status,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  typedef enum logic {
    S_IDLE,
    S_REDIRECT
  } state_t;

  state_t      r_state;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_mstatus;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mscratch;

  logic        w_hit;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_wr;
  logic [31:0] w_trap_mstatus;
  logic [31:0] w_mret_mstatus;

  // CSR read mux; unimplemented addresses read as zero
  always_comb begin
    w_hit = 1'b1;
    w_old = '0;
    case (csr_addr)
      A_MSTATUS:  w_old = r_mstatus;
      A_MTVEC:    w_old = r_mtvec;
      A_MSCRATCH: w_old = r_mscratch;
      A_MEPC:     w_old = r_mepc;
      A_MCAUSE:   w_old = r_mcause;
      default: begin
        w_hit = 1'b0;
        w_old = '0;
      end
    endcase
  end

  always_comb begin
    w_new = w_old;
    case (csr_op)
      2'b01:   w_new = csr_wdata;
      2'b10:   w_new = w_old | csr_wdata;
      2'b11:   w_new = w_old & ~csr_wdata;
      default: w_new = w_old;
    endcase
  end

  // RS/RC with a zero source are pure reads; events in the same cycle win
  assign w_wr = (r_state == S_IDLE) && csr_en && !exp_occur && !mret_occur &&
                w_hit && (csr_op != 2'b00) &&
                ((csr_op == 2'b01) || !csr_src_zero);

  always_comb begin
    w_trap_mstatus        = r_mstatus;
    w_trap_mstatus[7]     = r_mstatus[3];
    w_trap_mstatus[3]     = 1'b0;
    w_trap_mstatus[12:11] = 2'b00;
  end

  // MIE is restored from the MPIE held before the OR-mask is applied
  always_comb begin
    w_mret_mstatus    = r_mstatus | m_status_change;
    w_mret_mstatus[3] = r_mstatus[7];
    w_mret_mstatus[7] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_mstatus        <= RESET_MSTATUS;
      r_mtvec          <= {RESET_MTVEC[31:2], 2'b00};
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mscratch       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exp_occur) begin
            r_mepc           <= {mepc_change[31:1], 1'b0};
            r_mcause         <= mcause_change;
            r_mstatus        <= w_trap_mstatus;
            r_redirect_pc    <= {r_mtvec[31:2], 2'b00};
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIRECT;
          end else if (mret_occur) begin
            r_mstatus        <= w_mret_mstatus;
            r_redirect_pc    <= r_mepc;
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIRECT;
          end else if (w_wr) begin
            case (csr_addr)
              A_MSTATUS:  r_mstatus  <= w_new;
              A_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
              A_MSCRATCH: r_mscratch <= w_new;
              A_MEPC:     r_mepc     <= {w_new[31:1], 1'b0};
              A_MCAUSE:   r_mcause   <= w_new;
              default:    ;
            endcase
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_state          <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_rdata      = w_old;
  assign csr_addr_bad   = csr_en & ~w_hit;
  assign m_status       = r_mstatus;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_redirect_valid;

endmodule

// File: tb/tb_trap_csr_unit.sv
module tb_trap_csr_unit;

  logic        clk;
  logic        rst_n;
  logic        exp_occur;
  logic        mret_occur;
  logic [31:0] mepc_change;
  logic [31:0] mcause_change;
  logic [31:0] m_status_change;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic        redirect_ready;
  logic [31:0] csr_rdata;
  logic        csr_addr_bad;
  logic [31:0] m_status;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  trap_csr_unit #(
    .RESET_MTVEC  (32'h0000_0000),
    .RESET_MSTATUS(32'h0000_1800)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exp_occur      (exp_occur),
    .mret_occur     (mret_occur),
    .mepc_change    (mepc_change),
    .mcause_change  (mcause_change),
    .m_status_change(m_status_change),
    .csr_en         (csr_en),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_src_zero   (csr_src_zero),
    .redirect_ready (redirect_ready),
    .csr_rdata      (csr_rdata),
    .csr_addr_bad   (csr_addr_bad),
    .m_status       (m_status),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: CSR file as an address-keyed map plus redirect state
  logic [31:0] mc [logic [11:0]];
  logic        m_redir;
  logic [31:0] m_pc;

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        sz;
    logic [31:0] exp_rdata;
    logic        exp_bad;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mc.delete();
    mc[12'h300] = 32'h0000_1800;
    mc[12'h305] = 32'h0000_0000;
    mc[12'h340] = 32'h0;
    mc[12'h341] = 32'h0;
    mc[12'h342] = 32'h0;
    m_redir = 1'b0;
    m_pc    = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] st;
    logic [31:0] old;
    logic [31:0] nv;
    if (!m_redir) begin
      if (exp_occur) begin
        mc[12'h341] = mepc_change & ~32'h1;
        mc[12'h342] = mcause_change;
        st = mc[12'h300];
        st[7] = st[3];
        st[3] = 1'b0;
        st[12:11] = 2'b00;
        mc[12'h300] = st;
        m_pc = mc[12'h305] & ~32'h3;
        m_redir = 1'b1;
      end else if (mret_occur) begin
        st = mc[12'h300] | m_status_change;
        st[3] = mc[12'h300][7];
        st[7] = 1'b1;
        mc[12'h300] = st;
        m_pc = mc[12'h341];
        m_redir = 1'b1;
      end else if (csr_en && mc.exists(csr_addr) && csr_op != 2'b00 &&
                   !(csr_op != 2'b01 && csr_src_zero)) begin
        old = mc[csr_addr];
        if (csr_op == 2'b01)      nv = csr_wdata;
        else if (csr_op == 2'b10) nv = old | csr_wdata;
        else                      nv = old & ~csr_wdata;
        if (csr_addr == 12'h305) nv = nv & ~32'h3;
        if (csr_addr == 12'h341) nv = nv & ~32'h1;
        mc[csr_addr] = nv;
      end
    end else if (redirect_ready) begin
      m_redir = 1'b0;
    end
  endtask

  // Compare all outputs to the model, then clock one edge
  task automatic tick();
    logic [31:0] er;
    #1;
    er = mc.exists(csr_addr) ? mc[csr_addr] : 32'h0;
    check("rdata", csr_rdata, er);
    check("addr_bad", {31'b0, csr_addr_bad}, {31'b0, csr_en && !mc.exists(csr_addr)});
    check("m_status", m_status, mc[12'h300]);
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
    check("flush", {31'b0, flush}, {31'b0, m_redir});
    check("redirect_pc", redirect_pc, m_pc);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input logic en, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic sz);
    csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd; csr_src_zero = sz;
  endtask

  task automatic set_ev(input logic ex, input logic mr, input logic [31:0] pc,
                        input logic [31:0] cause, input logic [31:0] chg);
    exp_occur = ex; mret_occur = mr; mepc_change = pc; mcause_change = cause;
    m_status_change = chg;
  endtask

  logic [11:0] addr_pool [8];

  initial begin
    addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h340;
    addr_pool[3] = 12'h341; addr_pool[4] = 12'h342; addr_pool[5] = 12'h344;
    addr_pool[6] = 12'h7C0; addr_pool[7] = 12'hF14;

    rst_n = 1'b0;
    set_ev(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    set_csr(1'b0, 2'b00, 12'h0, 32'h0, 1'b0);
    redirect_ready = 1'b1;
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("reset_m_status", m_status, 32'h0000_1800);
    check("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);

    tbl.push_back('{1'b1, 2'b10, 12'h305, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 12'h305, 32'h8000_0103, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h305, 32'h0000_0000, 1'b1, 32'h8000_0100, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 12'h340, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h340, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 2'b11, 12'h340, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 2'b11, 12'h340, 32'h0000_00FF, 1'b0, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h340, 32'h0000_0001, 1'b0, 32'h1234_5600, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 12'h341, 32'h0000_0203, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h341, 32'h0000_0000, 1'b1, 32'h0000_0202, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 12'h342, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h342, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 12'h344, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 2'b01, 12'h300, 32'h0000_1808, 1'b0, 32'h0000_1800, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h300, 32'h0000_0000, 1'b1, 32'h0000_1808, 1'b0});
    tbl.push_back('{1'b1, 2'b00, 12'h340, 32'h0000_0000, 1'b0, 32'h1234_5601, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 12'h7C0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 12'h340, 32'h0000_0000, 1'b1, 32'h1234_5601, 1'b0});

    foreach (tbl[i]) begin
      set_csr(tbl[i].en, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].sz);
      #1;
      check($sformatf("tbl%0d_rdata", i), csr_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_bad", i), {31'b0, csr_addr_bad}, {31'b0, tbl[i].exp_bad});
      tick();
    end

    // Trap with mret and a CSR write in the same cycle: trap wins
    redirect_ready = 1'b0;
    set_ev(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0002, 32'h0000_1800);
    set_csr(1'b1, 2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0);
    tick();
    set_ev(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("trap_valid", {31'b0, redirect_valid}, 32'h1);
    check("trap_flush", {31'b0, flush}, 32'h1);
    check("trap_pc", redirect_pc, 32'h8000_0100);
    check("trap_mstatus", m_status, 32'h0000_0080);

    // Three cycles with ready low; events and writes inside REDIRECT are ignored
    set_csr(1'b1, 2'b10, 12'h341, 32'h0, 1'b1);
    #1 check("trap_mepc", csr_rdata, 32'h0000_0100);
    tick();
    check("hold1_valid", {31'b0, redirect_valid}, 32'h1);
    set_csr(1'b1, 2'b10, 12'h342, 32'h0, 1'b1);
    set_ev(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0007, 32'h0);
    #1 check("trap_mcause", csr_rdata, 32'h0000_0002);
    tick();
    set_ev(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("hold2_pc", redirect_pc, 32'h8000_0100);
    set_csr(1'b1, 2'b01, 12'h340, 32'h0, 1'b0);
    tick();
    check("hold3_flush", {31'b0, flush}, 32'h1);
    redirect_ready = 1'b1;
    set_csr(1'b1, 2'b10, 12'h340, 32'h0, 1'b1);
    #1 check("trap_mscratch_kept", csr_rdata, 32'h1234_5601);
    check("hold_last_valid", {31'b0, redirect_valid}, 32'h1);
    tick();
    check("return_valid", {31'b0, redirect_valid}, 32'h0);
    set_csr(1'b1, 2'b10, 12'h341, 32'h0, 1'b1);
    #1 check("ignored_exp_mepc", csr_rdata, 32'h0000_0100);

    // mret to 0x104
    set_csr(1'b1, 2'b01, 12'h341, 32'h0000_0104, 1'b0);
    tick();
    set_csr(1'b0, 2'b00, 12'h0, 32'h0, 1'b0);
    set_ev(1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_1800);
    tick();
    set_ev(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("mret_valid", {31'b0, redirect_valid}, 32'h1);
    check("mret_pc", redirect_pc, 32'h0000_0104);
    check("mret_mstatus", m_status, 32'h0000_1888);
    tick();
    check("mret_return", {31'b0, redirect_valid}, 32'h0);

    // Back-to-back trap on the first IDLE cycle, then reset mid-REDIRECT
    set_ev(1'b1, 1'b0, 32'h0000_0201, 32'h0000_000B, 32'h0);
    tick();
    set_ev(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("b2b_valid", {31'b0, redirect_valid}, 32'h1);
    check("b2b_mstatus", m_status, 32'h0000_0080);
    redirect_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, redirect_valid}, 32'h0);
    check("rst_mid_flush", {31'b0, flush}, 32'h0);
    check("rst_mid_pc", redirect_pc, 32'h0);
    check("rst_mid_mstatus", m_status, 32'h0000_1800);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      set_csr(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              addr_pool[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 3) == 0));
      set_ev(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), $urandom,
             $urandom, $urandom & ~32'h0000_0080);
      redirect_ready = $urandom_range(0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
